// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch mode/run controller.
// State encoding doubles as the LED/debug mode value.
package stopwatch_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_RUN     = 2'd0,
      ST_PAUSE   = 2'd1,
      ST_ADJ_SEC = 2'd2,
      ST_ADJ_MIN = 2'd3
   } state_t;

   // Digit positions on the 4-digit display, right to left.
   localparam int DIG_SEC_LO = 0;
   localparam int DIG_SEC_HI = 1;
   localparam int DIG_MIN_LO = 2;
   localparam int DIG_MIN_HI = 3;

   localparam logic [3:0] MASK_SEC = (4'b1 << DIG_SEC_LO) | (4'b1 << DIG_SEC_HI);
   localparam logic [3:0] MASK_MIN = (4'b1 << DIG_MIN_LO) | (4'b1 << DIG_MIN_HI);

   function automatic logic is_adj(input state_t s);
      return (s == ST_ADJ_SEC) || (s == ST_ADJ_MIN);
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Switch/tick inputs and counter/display strobes between the stopwatch
// controller (master) and the surrounding divider/counter/display logic (slave).
interface stopwatch_ctrl_if;
   import stopwatch_pkg::*;

   logic               pause;
   logic               adjust;
   logic               select;
   logic               tick_1hz;
   logic               tick_2hz;
   logic               count_en;
   logic               adj_sec_inc;
   logic               adj_min_inc;
   logic               clear_cnt;
   logic [3:0]         blink_mask;
   logic [STATE_W-1:0] mode;

   modport master (
      input  pause, adjust, select, tick_1hz, tick_2hz,
      output count_en, adj_sec_inc, adj_min_inc, clear_cnt, blink_mask, mode
   );

   modport slave (
      output pause, adjust, select, tick_1hz, tick_2hz,
      input  count_en, adj_sec_inc, adj_min_inc, clear_cnt, blink_mask, mode
   );

endinterface

// File: rtl/stopwatch_ctrl_btn_sync.sv
// Multi-flop synchronizer for a raw switch/button level, with a one-cycle
// rising-edge pulse derived from the synchronized level.
module btn_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic level,
   output logic rise
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples the pre-edge value.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// RUN/PAUSE/ADJ controller: synchronizes the user inputs, tracks the run/pause
// choice and drives registered counter strobes plus the adjust blink mask.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int BLINK_DIV   = 1
) (
   input  logic              clock_100mhz,
   input  logic              reset,
   stopwatch_ctrl_if.master  bus
);

   localparam int                DIV_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BLINK_DIV - 1);

   logic pause_rise, adjust_s, select_s;
   logic adjust_rise, select_rise;
   logic [1:0] unused_edges;

   state_t           state_q, state_d;
   logic             paused_q, paused_d;
   logic             blink_phase_q;
   logic [DIV_W-1:0] blink_div_q;
   logic             clr_hold_q, clear_q;
   logic             count_en_q, adj_sec_q, adj_min_q;
   logic [3:0]       blink_mask;

   btn_sync #(.STAGES(SYNC_STAGES)) u_sync_pause (
      .clk(clock_100mhz), .reset(reset), .d(bus.pause), .level(), .rise(pause_rise)
   );
   btn_sync #(.STAGES(SYNC_STAGES)) u_sync_adjust (
      .clk(clock_100mhz), .reset(reset), .d(bus.adjust), .level(adjust_s), .rise(adjust_rise)
   );
   btn_sync #(.STAGES(SYNC_STAGES)) u_sync_select (
      .clk(clock_100mhz), .reset(reset), .d(bus.select), .level(select_s), .rise(select_rise)
   );

   assign unused_edges = {adjust_rise, select_rise};

   // paused_q keeps toggling inside adjust so the choice is honoured on exit.
   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      paused_d = paused_q ^ pause_rise;
      state_d  = paused_d ? ST_PAUSE : ST_RUN;
      if (adjust_s)
         state_d = select_s ? ST_ADJ_MIN : ST_ADJ_SEC;
   end

   always_ff @(posedge clock_100mhz) begin
      if (reset) begin
         state_q       <= ST_RUN;
         paused_q      <= 1'b0;
         blink_phase_q <= 1'b0;
         blink_div_q   <= '0;
         clr_hold_q    <= 1'b1;
         clear_q       <= 1'b1;
         count_en_q    <= 1'b0;
         adj_sec_q     <= 1'b0;
         adj_min_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         paused_q   <= paused_d;
         clr_hold_q <= 1'b0;
         clear_q    <= clr_hold_q;
         count_en_q <= bus.tick_1hz & (state_q == ST_RUN);
         adj_sec_q  <= bus.tick_2hz & (state_q == ST_ADJ_SEC);
         adj_min_q  <= bus.tick_2hz & (state_q == ST_ADJ_MIN);

         if (!is_adj(state_d)) begin
            blink_phase_q <= 1'b0;
            blink_div_q   <= '0;
         end else if (is_adj(state_q) && bus.tick_2hz) begin
            if (blink_div_q == DIV_LAST) begin
               blink_div_q   <= '0;
               blink_phase_q <= ~blink_phase_q;
            end else begin
               blink_div_q <= blink_div_q + 1'b1;
            end
         end
      end
   end

   always_comb begin
      blink_mask = '0;
      if (blink_phase_q) begin
         if (state_q == ST_ADJ_MIN) blink_mask = MASK_MIN;
         if (state_q == ST_ADJ_SEC) blink_mask = MASK_SEC;
      end
   end

   assign bus.count_en    = count_en_q;
   assign bus.adj_sec_inc = adj_sec_q;
   assign bus.adj_min_inc = adj_min_q;
   assign bus.clear_cnt   = clear_q;
   assign bus.blink_mask  = blink_mask;
   assign bus.mode        = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: reset/clear stretch, counting, pause,
// adjust with blink mask, coincident tick/pause and reset during adjust.
module tb_stopwatch_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   stopwatch_ctrl_if bus ();

   stopwatch_ctrl #(.SYNC_STAGES(2), .BLINK_DIV(1)) dut (
      .clock_100mhz(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 ns past the last one.
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_1hz();
      bus.tick_1hz = 1'b1;
      cyc(1);
      bus.tick_1hz = 1'b0;
   endtask

   task automatic pulse_2hz();
      bus.tick_2hz = 1'b1;
      cyc(1);
      bus.tick_2hz = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int bad;
      int pulses;
      reset        = 1'b1;
      bus.pause    = 1'b0;
      bus.adjust   = 1'b0;
      bus.select   = 1'b0;
      bus.tick_1hz = 1'b0;
      bus.tick_2hz = 1'b0;

      // 1: three reset edges, clear stretched one cycle past reset
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         check("rst_clear", bus.clear_cnt, 1'b1);
         check("rst_mode", bus.mode, 2'd0);
         check("rst_strobes", {bus.count_en, bus.adj_sec_inc, bus.adj_min_inc}, 3'b000);
         check("rst_mask", bus.blink_mask, 4'b0000);
      end
      reset = 1'b0;
      cyc(1);
      check("clear_stretch", bus.clear_cnt, 1'b1);
      cyc(1);
      check("clear_drop", bus.clear_cnt, 1'b0);

      // 2: RUN, tick_1hz every 10 cycles for 50 cycles
      bad = 0;
      pulses = 0;
      for (int i = 0; i < 50; i++) begin
         bus.tick_1hz = (i % 10 == 0);
         cyc(1);
         bus.tick_1hz = 1'b0;
         if (bus.count_en !== (i % 10 == 0)) bad++;
         if (bus.count_en === 1'b1) pulses++;
      end
      check("run_pulse_pos", bad, 0);
      check("run_pulses", pulses, 5);

      // 3: pause press lands on the 3rd edge, held press toggles once
      bus.pause = 1'b1;
      cyc(2);
      check("pause_pre", bus.mode, 2'd0);
      cyc(1);
      check("pause_land", bus.mode, 2'd1);
      pulse_1hz();
      check("pause_no_count", bus.count_en, 1'b0);
      cyc(14);
      check("pause_held", bus.mode, 2'd1);
      bus.pause = 1'b0;
      cyc(4);
      bus.pause = 1'b1;
      cyc(3);
      check("resume_mode", bus.mode, 2'd0);
      bus.pause = 1'b0;
      cyc(2);
      pulse_1hz();
      check("resume_count", bus.count_en, 1'b1);

      // 4: adjust minutes, then seconds
      bus.adjust = 1'b1;
      bus.select = 1'b1;
      cyc(3);
      check("adj_min_mode", bus.mode, 2'd3);
      check("adj_min_mask0", bus.blink_mask, 4'b0000);
      bad = 0;
      for (int k = 0; k < 4; k++) begin
         pulse_2hz();
         if (bus.adj_min_inc !== 1'b1) bad++;
         if (bus.blink_mask !== ((k % 2 == 0) ? 4'b1100 : 4'b0000)) bad++;
         pulse_1hz();
         if (bus.count_en !== 1'b0 || bus.adj_min_inc !== 1'b0) bad++;
      end
      check("adj_min_seq", bad, 0);
      pulse_2hz();
      check("adj_min_mask1", bus.blink_mask, 4'b1100);
      bus.select = 1'b0;
      cyc(3);
      check("adj_sec_mode", bus.mode, 2'd2);
      check("adj_sec_mask1", bus.blink_mask, 4'b0011);
      pulse_2hz();
      check("adj_sec_inc", {bus.adj_sec_inc, bus.adj_min_inc}, 2'b10);
      check("adj_sec_mask0", bus.blink_mask, 4'b0000);
      cyc(1);
      check("adj_sec_width", bus.adj_sec_inc, 1'b0);
      pulse_2hz();
      check("adj_sec_mask2", bus.blink_mask, 4'b0011);

      // 5: pause during adjust takes effect on exit
      bus.pause = 1'b1;
      cyc(3);
      check("adj_pause_hidden", bus.mode, 2'd2);
      bus.pause = 1'b0;
      cyc(2);
      bus.adjust = 1'b0;
      cyc(2);
      check("adj_exit_pre", bus.mode, 2'd2);
      cyc(1);
      check("adj_exit_pause", bus.mode, 2'd1);
      check("adj_exit_mask", bus.blink_mask, 4'b0000);
      pulse_1hz();
      check("paused_1hz", bus.count_en, 1'b0);
      pulse_2hz();
      check("paused_2hz", {bus.adj_sec_inc, bus.adj_min_inc}, 2'b00);
      bus.pause = 1'b1;
      cyc(3);
      check("unpause_mode", bus.mode, 2'd0);
      bus.pause = 1'b0;
      cyc(2);

      // 6: tick_1hz coincident with pause_rise in RUN
      bus.pause = 1'b1;
      cyc(2);
      bus.tick_1hz = 1'b1;
      cyc(1);
      bus.tick_1hz = 1'b0;
      check("coinc_count", bus.count_en, 1'b1);
      check("coinc_mode", bus.mode, 2'd1);
      cyc(1);
      check("coinc_width", bus.count_en, 1'b0);
      pulse_1hz();
      check("coinc_after", bus.count_en, 1'b0);
      bus.pause = 1'b0;
      cyc(2);
      bus.pause = 1'b1;
      cyc(3);
      check("coinc_resume", bus.mode, 2'd0);
      bus.pause = 1'b0;

      // 6b: reset during ADJ_MIN with adjust held high
      bus.adjust = 1'b1;
      bus.select = 1'b1;
      cyc(3);
      check("pre_reset_adj", bus.mode, 2'd3);
      reset = 1'b1;
      cyc(1);
      check("reset_adj_mode", bus.mode, 2'd0);
      check("reset_adj_clear", bus.clear_cnt, 1'b1);
      cyc(1);
      reset = 1'b0;
      cyc(1);
      check("post_reset_mode1", bus.mode, 2'd0);
      check("post_reset_clear1", bus.clear_cnt, 1'b1);
      cyc(1);
      check("post_reset_mode2", bus.mode, 2'd0);
      check("post_reset_clear2", bus.clear_cnt, 1'b0);
      cyc(1);
      check("reset_reenter_adj", bus.mode, 2'd3);
      bus.adjust = 1'b0;
      cyc(3);
      check("post_reset_run", bus.mode, 2'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
